// File: rtl/ccr_pkg.sv
// Shared constants for the condition-code register and its shadow stack.
package ccr_pkg;

   localparam int unsigned CCR_CARRY  = 0;
   localparam int unsigned CCR_ZERO   = 1;
   localparam int unsigned CCR_SIGN   = 2;
   localparam int unsigned CCR_OVF    = 3;

   localparam int unsigned NFLAGS_DEF = 4;
   localparam int unsigned DEPTH_DEF  = 4;

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved ccr snapshots; simultaneous push and pop, push-when-full and
// pop-when-empty leave storage and level untouched.
module ccr_shadow_stack
   import ccr_pkg::*;
#(
   parameter int unsigned WIDTH = NFLAGS_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level <= '0;
      end else if (do_push) begin
         level <= level + LW'(1);
      end else if (do_pop) begin
         level <= level - LW'(1);
      end
   end

   // Entry written at the current level; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (rst_n && do_push && (level == LW'(i))) begin
            mem[i] <= din;
         end
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (level == LW'(i + 1)) begin
            dout = mem[i];
         end
      end
   end

endmodule

// File: rtl/ccr_stack_unit.sv
// Condition-code register with masked load, shadow-stack save/restore,
// sticky stack error flags and a selectable condition test.
module ccr_stack_unit
   import ccr_pkg::*;
#(
   parameter int unsigned NFLAGS = NFLAGS_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ld,
   input  logic [NFLAGS-1:0]             flag_we,
   input  logic [NFLAGS-1:0]             flags_in,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          err_clr,
   input  logic [$clog2(NFLAGS)-1:0]     cond_idx,
   input  logic                          cond_neg,
   output logic [NFLAGS-1:0]             ccr,
   output logic                          cond_true,
   output logic                          led_ld,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          full,
   output logic                          empty,
   output logic                          ovf_err,
   output logic                          unf_err
);

   logic [NFLAGS-1:0] stack_top;
   logic [NFLAGS-1:0] base;
   logic [NFLAGS-1:0] we_eff;
   logic [NFLAGS-1:0] ccr_nxt;
   logic [NFLAGS-1:0] cond_sel;
   logic              pop_ok;
   logic              ovf_set;
   logic              unf_set;

   ccr_shadow_stack #(
      .WIDTH (NFLAGS),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (ccr),
      .dout  (stack_top),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // Restored context forms the base; ld then overrides the masked bits.
   assign pop_ok  = pop & ~push & ~empty;
   assign base    = pop_ok ? stack_top : ccr;
   assign we_eff  = flag_we & {NFLAGS{ld}};
   assign ccr_nxt = (base & ~we_eff) | (flags_in & we_eff);

   assign ovf_set = push & (full | pop);
   assign unf_set = pop & (empty | push);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ccr     <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         ccr     <= ccr_nxt;
         ovf_err <= ovf_set | (ovf_err & ~err_clr);
         unf_err <= unf_set | (unf_err & ~err_clr);
      end
   end

   // Out-of-range indices shift the select bit away, so the test reads 0.
   assign cond_sel  = NFLAGS'(1) << cond_idx;
   assign cond_true = (|(ccr & cond_sel)) ^ cond_neg;
   assign led_ld    = ld;

endmodule

// File: tb/tb_ccr_stack_unit.sv
// Directed bench for ccr_stack_unit (NFLAGS=4, DEPTH=4).
module tb_ccr_stack_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ld;
   logic [3:0] flag_we;
   logic [3:0] flags_in;
   logic       push;
   logic       pop;
   logic       err_clr;
   logic [1:0] cond_idx;
   logic       cond_neg;
   logic [3:0] ccr;
   logic       cond_true;
   logic       led_ld;
   logic [2:0] level;
   logic       full;
   logic       empty;
   logic       ovf_err;
   logic       unf_err;

   int vectors = 0;
   int errors  = 0;

   ccr_stack_unit #(.NFLAGS(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld        (ld),
      .flag_we   (flag_we),
      .flags_in  (flags_in),
      .push      (push),
      .pop       (pop),
      .err_clr   (err_clr),
      .cond_idx  (cond_idx),
      .cond_neg  (cond_neg),
      .ccr       (ccr),
      .cond_true (cond_true),
      .led_ld    (led_ld),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .ovf_err   (ovf_err),
      .unf_err   (unf_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ld = 1'b0; flag_we = 4'b0000; flags_in = 4'b0000;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   task automatic load(input logic [3:0] v);
      ld = 1'b1; flag_we = 4'b1111; flags_in = v;
      step();
      idle();
   endtask

   initial begin
      rst_n = 1'b0; cond_idx = 2'd0; cond_neg = 1'b0;
      idle();
      ld = 1'b1; flag_we = 4'b1111; flags_in = 4'b1111; push = 1'b1;
      step(); step();
      rst_n = 1'b1;
      idle();
      check("rst_ccr", 32'(ccr), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_full", 32'(full), 32'h0);
      check("rst_ovf", 32'(ovf_err), 32'h0);
      check("rst_unf", 32'(unf_err), 32'h0);

      // basic load and condition test
      ld = 1'b1; flag_we = 4'b1111; flags_in = 4'b1010;
      #1 check("led_ld_on", 32'(led_ld), 32'h1);
      check("ccr_not_comb", 32'(ccr), 32'h0);
      step(); idle();
      check("led_ld_off", 32'(led_ld), 32'h0);
      check("ld_ccr", 32'(ccr), 32'hA);
      cond_idx = 2'd1; cond_neg = 1'b0;
      #1 check("cond_z", 32'(cond_true), 32'h1);
      cond_neg = 1'b1;
      #1 check("cond_z_neg", 32'(cond_true), 32'h0);
      cond_idx = 2'd0; cond_neg = 1'b0;
      #1 check("cond_c", 32'(cond_true), 32'h0);
      cond_idx = 2'd3;
      #1 check("cond_v", 32'(cond_true), 32'h1);

      // ld with empty write mask, then a partial mask
      ld = 1'b1; flag_we = 4'b0000; flags_in = 4'b0101;
      step(); idle();
      check("we_zero", 32'(ccr), 32'hA);
      ld = 1'b1; flag_we = 4'b0011; flags_in = 4'b0101;
      step(); idle();
      check("we_part", 32'(ccr), 32'h9);

      // push saves pre-update ccr; pop restores it
      load(4'b0001);
      push = 1'b1; ld = 1'b1; flag_we = 4'b1111; flags_in = 4'b0110;
      step(); idle();
      check("push_ccr", 32'(ccr), 32'h6);
      check("push_level", 32'(level), 32'h1);
      pop = 1'b1;
      step(); idle();
      check("pop_ccr", 32'(ccr), 32'h1);
      check("pop_level", 32'(level), 32'h0);
      check("pop_unf", 32'(unf_err), 32'h0);

      // fill past depth: saved 1,2,3,4 then overflow
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; ld = 1'b1; flag_we = 4'b1111; flags_in = 4'(i + 2);
         step();
      end
      idle();
      check("fill_level", 32'(level), 32'h4);
      check("fill_full", 32'(full), 32'h1);
      check("fill_ovf", 32'(ovf_err), 32'h1);
      check("fill_ccr", 32'(ccr), 32'h6);
      pop = 1'b1; step(); check("lifo_0", 32'(ccr), 32'h4);
      step(); check("lifo_1", 32'(ccr), 32'h3);
      step(); check("lifo_2", 32'(ccr), 32'h2);
      step(); check("lifo_3", 32'(ccr), 32'h1);
      check("drain_empty", 32'(empty), 32'h1);
      check("drain_unf", 32'(unf_err), 32'h0);
      step(); idle();
      check("under_unf", 32'(unf_err), 32'h1);
      check("under_ccr", 32'(ccr), 32'h1);
      err_clr = 1'b1;
      step(); idle();
      check("clr_ovf", 32'(ovf_err), 32'h0);
      check("clr_unf", 32'(unf_err), 32'h0);

      // pop merged with masked ld
      load(4'b1100);
      push = 1'b1; step(); idle();
      load(4'b0010);
      pop = 1'b1; ld = 1'b1; flag_we = 4'b0001; flags_in = 4'b0001;
      step(); idle();
      check("pop_ld_ccr", 32'(ccr), 32'hD);
      check("pop_ld_level", 32'(level), 32'h0);

      // new error beats err_clr in the same cycle
      pop = 1'b1; err_clr = 1'b1;
      step(); idle();
      check("set_wins", 32'(unf_err), 32'h1);
      err_clr = 1'b1;
      step(); idle();
      check("set_cleared", 32'(unf_err), 32'h0);

      // push+pop together at level 2
      push = 1'b1; step(); step(); idle();
      check("lvl2", 32'(level), 32'h2);
      push = 1'b1; pop = 1'b1; ld = 1'b1; flag_we = 4'b1111; flags_in = 4'b1001;
      step(); idle();
      check("pp_level", 32'(level), 32'h2);
      check("pp_ovf", 32'(ovf_err), 32'h1);
      check("pp_unf", 32'(unf_err), 32'h1);
      check("pp_ccr", 32'(ccr), 32'h9);
      err_clr = 1'b1;
      step(); idle();
      check("pp_clr_ovf", 32'(ovf_err), 32'h0);
      check("pp_clr_unf", 32'(unf_err), 32'h0);
      check("pp_clr_level", 32'(level), 32'h2);

      // reset mid-sequence discards stacked context
      push = 1'b1; step(); idle();
      check("lvl3", 32'(level), 32'h3);
      rst_n = 1'b0; push = 1'b1; ld = 1'b1; flag_we = 4'b1111; flags_in = 4'b1111;
      step();
      rst_n = 1'b1; idle();
      check("mid_rst_level", 32'(level), 32'h0);
      check("mid_rst_ccr", 32'(ccr), 32'h0);
      check("mid_rst_empty", 32'(empty), 32'h1);
      pop = 1'b1; step(); idle();
      check("mid_rst_unf", 32'(unf_err), 32'h1);
      check("mid_rst_pop_ccr", 32'(ccr), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
